// File: rtl/instr_fetch_pkg.sv
// Shared types and sizing for the instruction fetch block.
package instr_fetch_pkg;
  localparam int MEM_BYTES   = 1024;
  localparam int ADDR_W      = 10;
  localparam int CLEAR_WORDS = MEM_BYTES / 4;

  typedef enum logic [1:0] {
    CLEAR,
    LOAD,
    RUN,
    ERR
  } state_t;
endpackage

// File: rtl/instr_mem.sv
// Byte-laned instruction store: byte write, word clear, combinational aligned word read.
// No flow control; clear takes priority over a byte write in the same cycle.
module instr_mem
  import instr_fetch_pkg::*;
#(
  parameter int MEM_BYTES = instr_fetch_pkg::MEM_BYTES,
  parameter int ADDR_W    = instr_fetch_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              clr,
  input  logic [ADDR_W-3:0] clr_idx,
  input  logic [ADDR_W-3:0] raddr,
  output logic [31:0]       rdata
);
  localparam int WORDS = MEM_BYTES / 4;

  logic [7:0] lane [4][WORDS];

  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (clr) begin
        lane[l][clr_idx] <= '0;
      end else if (we && waddr[1:0] == 2'(l)) begin
        lane[l][waddr[ADDR_W-1:2]] <= wdata;
      end
    end
  end

  assign rdata = {lane[3][raddr], lane[2][raddr], lane[1][raddr], lane[0][raddr]};
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: clears memory, accepts host byte loads, then streams words with 1-cycle latency.
// stall freezes outputs; redirect overrides stall and inserts one bubble; misaligned redirect is fatal.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int MEM_BYTES = instr_fetch_pkg::MEM_BYTES,
  parameter int ADDR_W    = instr_fetch_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  input  logic              start,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       pc,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  output logic              busy,
  output logic              misalign_err
);
  localparam int WORD_W = ADDR_W - 2;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] fetch_addr;
  logic [31:0]       rd_word;
  logic              mem_we, mem_clr;
  logic              misaligned;

  assign misaligned = redirect_pc[1:0] != 2'b00;
  assign busy       = state_q == CLEAR;

  always_comb begin
    state_d = state_q;
    mem_we  = 1'b0;
    mem_clr = 1'b0;
    case (state_q)
      CLEAR: begin
        mem_clr = 1'b1;
        // Word count is a power of two, so the last word is all-ones.
        if (&clr_cnt) state_d = LOAD;
      end
      LOAD: begin
        mem_we = load_we;
        if (start) state_d = RUN;
      end
      RUN: begin
        if (redirect && misaligned) state_d = ERR;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEAR;
      clr_cnt      <= '0;
      fetch_addr   <= '0;
      pc           <= '0;
      instruction  <= '0;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        CLEAR: clr_cnt <= clr_cnt + WORD_W'(1);
        LOAD: begin
          if (start) fetch_addr <= '0;
        end
        RUN: begin
          if (redirect) begin
            instr_valid <= 1'b0;
            if (misaligned) misalign_err <= 1'b1;
            else            fetch_addr   <= redirect_pc[ADDR_W-1:0];
          end else if (!stall) begin
            pc          <= 32'(fetch_addr);
            instruction <= rd_word;
            instr_valid <= 1'b1;
            fetch_addr  <= fetch_addr + ADDR_W'(4);
          end
        end
        default: ;
      endcase
    end
  end

  instr_mem #(
    .MEM_BYTES(MEM_BYTES),
    .ADDR_W   (ADDR_W)
  ) u_mem (
    .clk    (clk),
    .we     (mem_we),
    .waddr  (load_addr),
    .wdata  (load_data),
    .clr    (mem_clr),
    .clr_idx(clr_cnt),
    .raddr  (fetch_addr[ADDR_W-1:2]),
    .rdata  (rd_word)
  );
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench: the driver steps a behavioural model and queues per-cycle expectations; the monitor compares.
module tb_instr_fetch;
  localparam int MB = 1024;

  logic        clk = 1'b0;
  logic        rst, load_we, start, stall, redirect;
  logic [9:0]  load_addr;
  logic [7:0]  load_data;
  logic [31:0] redirect_pc;
  logic [31:0] pc, instruction;
  logic        instr_valid, busy, misalign_err;

  instr_fetch dut (
    .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .start(start), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .pc(pc), .instruction(instruction), .instr_valid(instr_valid), .busy(busy),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        vld;
    logic        busy;
    logic        err;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Behavioural reference: byte array plus a few scalar facts about what the fetcher is doing.
  logic [7:0]  m_mem [MB];
  int          m_fa, m_clear_left;
  logic [31:0] m_pc, m_ins;
  logic        m_vld, m_err;
  bit          m_clearing, m_loading, m_fetching, m_halted;

  function automatic logic [31:0] m_word(input int a);
    return {m_mem[a+3], m_mem[a+2], m_mem[a+1], m_mem[a]};
  endfunction

  task automatic step(input logic r, input logic w, input int a, input logic [7:0] d,
                      input logic s, input logic st, input logic rd, input logic [31:0] rp);
    rst = r; load_we = w; load_addr = a[9:0]; load_data = d;
    start = s; stall = st; redirect = rd; redirect_pc = rp;
    if (r) begin
      m_pc = 0; m_ins = 0; m_vld = 0; m_err = 0; m_fa = 0;
      m_clear_left = MB / 4;
      m_clearing = 1; m_loading = 0; m_fetching = 0; m_halted = 0;
      for (int i = 0; i < MB; i++) m_mem[i] = 8'h00;
    end else if (m_clearing) begin
      m_clear_left--;
      if (m_clear_left == 0) begin m_clearing = 0; m_loading = 1; end
    end else if (m_loading) begin
      if (w) m_mem[a % MB] = d;
      if (s) begin m_loading = 0; m_fetching = 1; m_fa = 0; end
    end else if (m_fetching) begin
      if (rd) begin
        m_vld = 0;
        if (rp % 4 != 0) begin m_err = 1; m_fetching = 0; m_halted = 1; end
        else m_fa = int'(rp % MB);
      end else if (!st) begin
        m_pc = m_fa; m_ins = m_word(m_fa); m_vld = 1;
        m_fa = (m_fa + 4) % MB;
      end
    end
    exp_q.push_back({m_pc, m_ins, m_vld, m_clearing, m_err});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 0, 0, 0, 32'h0);
  endtask

  task automatic noisy(input int n);
    for (int i = 0; i < n; i++)
      step(0, 1'($urandom), int'($urandom_range(0, MB - 1)), 8'($urandom),
           1'($urandom), 1'($urandom), 0, 32'h0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e, g;
      e = exp_q.pop_front();
      g = {pc, instruction, instr_valid, busy, misalign_err};
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL cycle_check t=%0t got pc=%h ins=%h vld=%b busy=%b err=%b exp pc=%h ins=%h vld=%b busy=%b err=%b",
                 $time, g.pc, g.ins, g.vld, g.busy, g.err, e.pc, e.ins, e.vld, e.busy, e.err);
      end
    end
  end

  initial begin
    logic [7:0] s2 [8];
    s2 = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h01, 8'h00};

    // Reset then clear; load/start noise during clear must be ignored.
    step(1, 0, 0, 8'h00, 0, 0, 0, 32'h0);
    for (int i = 0; i < MB / 4; i++)
      step(0, 1'($urandom), int'($urandom_range(0, MB - 1)), 8'($urandom), 1'($urandom), 0, 0, 32'h0);
    idle(3);

    // Known words at 0 and 4, random elsewhere; a load in the start cycle still lands.
    for (int i = 0; i < 8; i++) step(0, 1, i, s2[i], 0, 0, 0, 32'h0);
    for (int i = 8; i < MB; i++) step(0, 1, i, 8'($urandom), 0, 0, 0, 32'h0);
    step(0, 1, 8, 8'hA5, 1, 0, 0, 32'h0);
    idle(2);

    // Stall at pc=4, then resume.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 0, 1, 0, 32'h0);
    idle(2);

    // Redirect under stall, then a redirect with junk upper bits to exercise the wrap.
    step(0, 0, 0, 8'h00, 0, 1, 1, 32'h14);
    idle(4);
    step(0, 0, 0, 8'h00, 0, 0, 1, 32'hABCD_03F8);
    idle(5);

    // Random run: stalls, aligned redirects, ignored loads.
    for (int i = 0; i < 300; i++)
      step(0, 1'($urandom), int'($urandom_range(0, MB - 1)), 8'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), $urandom & 32'hFFFF_FFFC);

    // Misaligned redirect is sticky until reset.
    step(0, 0, 0, 8'h00, 0, 0, 1, 32'h6);
    noisy(10);
    step(1, 0, 0, 8'h00, 0, 0, 0, 32'h0);
    idle(MB / 4);

    // Nonzero data, run, reset mid-run and mid-clear, then everything must read zero.
    for (int i = 0; i < 40; i++) step(0, 1, int'($urandom_range(0, MB - 1)), 8'($urandom_range(1, 255)), 0, 0, 0, 32'h0);
    step(0, 1, 0, 8'h77, 1, 0, 0, 32'h0);
    idle(12);
    step(1, 0, 0, 8'h00, 0, 0, 0, 32'h0);
    idle(100);
    step(1, 0, 0, 8'h00, 0, 0, 0, 32'h0);
    idle(MB / 4);
    step(0, 0, 0, 8'h00, 1, 0, 0, 32'h0);
    idle(MB / 4 + 4);

    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
